// File: rtl/pwm_ramp_controller.sv
// rtl/pwm_ramp_controller.sv - duty-cycle ramp sequencer between the SPI duty register and the PWM
// Walks duty_out toward target_duty in step_size increments every step_period+1 clocks; bypass when disabled.
module pwm_ramp_controller #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [7:0]          target_duty,
  input  logic [3:0]          step_size,
  input  logic [PERIOD_W-1:0] step_period,
  output logic [7:0]          duty_out,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_BYPASS = 2'd2
  } state_t;

  state_t              state;
  logic [PERIOD_W-1:0] counter;

  logic       step_up;
  logic [8:0] diff;
  logic [8:0] step_eff;
  logic [7:0] step_mag;
  logic [7:0] next_duty;

  // Step magnitude is clamped to the remaining distance, so no overshoot or wrap is possible.
  always_comb begin
    step_up   = 1'b0;
    diff      = 9'd0;
    step_eff  = 9'd0;
    step_mag  = 8'd0;
    next_duty = duty_out;
    step_up   = target_duty > duty_out;
    diff      = step_up ? ({1'b0, target_duty} - {1'b0, duty_out})
                        : ({1'b0, duty_out} - {1'b0, target_duty});
    step_eff  = {5'd0, (step_size == 4'd0) ? 4'd1 : step_size};
    step_mag  = (diff < step_eff) ? diff[7:0] : step_eff[7:0];
    next_duty = step_up ? (duty_out + step_mag) : (duty_out - step_mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      counter  <= '0;
      duty_out <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state    <= ST_BYPASS;
        counter  <= '0;
        duty_out <= target_duty;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_BYPASS: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          ST_IDLE: begin
            if (target_duty != duty_out) begin
              state   <= ST_RAMP;
              counter <= '0;
              busy    <= 1'b1;
            end
          end
          ST_RAMP: begin
            if (target_duty == duty_out) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (counter >= step_period) begin
              counter  <= '0;
              duty_out <= next_duty;
              if (next_duty == target_duty) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              counter <= counter + {{(PERIOD_W-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Sequences the 8-bit duty-cycle value fed to the PWM peripheral. The SPI-written duty register becomes a target: the output walks toward it in programmable steps at a programmable rate, which gives soft-start and fade instead of abrupt duty jumps. It sits between the SPI peripheral's duty register output and the PWM peripheral's duty input in the top level. A bypass mode passes the target straight through.

## Interface
Parameters:
- PERIOD_W, 16, width of the step-period counter and of `step_period`

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = ramp mode; 0 = bypass (duty_out follows target_duty)
- target_duty  in  8  requested duty (SPI register value)
- step_size  in  4  duty increment per step, in LSBs; 0 is treated as 1
- step_period  in  PERIOD_W  a step occurs every step_period+1 clk cycles
- duty_out  out  8  registered duty value to the PWM peripheral
- busy  out  1  high while in RAMP
- done  out  1  one-cycle pulse when a ramp reaches its target

## Operation
- Reset values: duty_out=0, busy=0, done=0, counter=0, state=IDLE. Reset is asynchronous and may be asserted at any cycle. Mid-ramp, reset forces those values immediately, with no done pulse.
- State BYPASS (enable=0): every edge duty_out<=target_duty, counter<=0, busy=0, done=0. From any state, enable=0 moves to BYPASS on the next edge, and duty_out loads target on that same edge.
- BYPASS -> IDLE on the first edge with enable=1. duty_out holds its value.
- IDLE: if target_duty != duty_out, go to RAMP on the next edge, with counter<=0 and busy<=1. Otherwise stay in IDLE.
- RAMP, each edge:
  - Early exit: if target_duty == duty_out, go to IDLE with busy<=0 and done<=1. This covers the target being moved back onto duty_out.
  - Else, if counter >= step_period (a step): counter<=0, and duty_out moves toward target_duty by min(S, |target_duty - duty_out|), where S = max(step_size, 1).
    - If that step lands on the target, go to IDLE on the same edge, with busy<=0 and done<=1.
  - Else: counter<=counter+1.
- Arithmetic:
  - Compare and compute the difference unsigned, at 9 bits.
  - Never overshoot. Never wrap: 250 + step 15 toward 255 gives 255, and 3 - 15 toward 0 gives 0.
- Direction is re-evaluated on every step from the live target_duty. A target change mid-ramp does not reset the counter.
- Inputs step_size and step_period are sampled live every cycle. Using >= means that shrinking step_period below the current count triggers a step on the next edge.
- done is high for exactly one cycle per ramp completion. It is never asserted in BYPASS.

## Timing
- Ramp timing: target changes before edge E0 with enable=1 in IDLE.
  - At E0: RAMP, counter=0.
  - Steps land on edges E0+(P+1)·k, k=1..ceil(D/S), where P=step_period and D=|target-duty|.
  - The final step sets duty_out=target, done=1 and busy=0 together. done clears on the next edge.
- P=0 gives one step per clock.
- Latency from a target write to the first duty_out change: P+2 edges (IDLE→RAMP edge plus P+1).
- Bypass latency: 1 edge from target_duty to duty_out.
- Simultaneous events:
  - enable falling on a step edge: BYPASS wins, and duty_out<=target.
  - Target change on the completing edge: the completion uses the pre-edge target. IDLE then re-enters RAMP on the next edge.

## Test plan
- Reset: assert rst_n=0 mid-ramp asynchronously (between edges) -> duty_out=0, busy=0, done=0 immediately; after release, stays in IDLE with target=0.
- Up-ramp: enable=1, step_size=4, step_period=9, target 0→20 -> duty_out reads 4, 8, 12, 16, 20. Changes land every 10 cycles, the first at E0+10. done pulses once with 20. busy is high from E0 through the final step.
- Saturation and step 0:
  - step_size=15, duty 250 → target 255 -> single step to 255.
  - step_size=0, 5 → 2 -> 4, 3, 2, with P=0, one per clock.
- Reversal mid-ramp: ramp 0→100 with step 10 at P=3. After duty=30, set target=10 -> next step 20, then 10, then done. The counter is not restarted at the reversal.
- Bypass: enable=0 while ramping at duty 40 toward 200 -> duty_out=200 on the next edge. No done; busy=0. Re-enable, then target=0 -> ramps down from 200.
- Early exit: in RAMP at duty 50, target momentarily 60 then back to 50 before any step -> IDLE next edge, one done pulse, duty_out stays 50.
